dplca_txop_table: RTL

//  Maintains the DPLCA TXOP claim table, one 2-bit claim per TXOP ID (0..255), from observed bus activity.

---
 rtl/dplca_pkg.sv | 39 +++
 rtl/dplca_age_counter.sv | 59 +++++
 rtl/dplca_txop_table.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dplca_pkg.sv
// Shared DPLCA definitions: claim encodings, on/off and status codes, command codes, FSM states.
// The SOFT encoding is only produced when DPLCA_SOFT_CLAIM_EN is defined (see dplca_txop_table).
package dplca_pkg;

    localparam int NODE_ID_W_DEF = 8;

    localparam logic [1:0] CLAIM_UNCLAIMED = 2'b00;
    localparam logic [1:0] CLAIM_SOFT      = 2'b01;
    localparam logic [1:0] CLAIM_HARD      = 2'b10;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    localparam logic OK   = 1'b0;
    localparam logic FAIL = 1'b1;

    typedef enum logic [1:0] {
        CMD_NONE   = 2'd0,
        CMD_BEACON = 2'd1,
        CMD_COMMIT = 2'd2
    } cmd_e;

    typedef enum logic [1:0] {
        ST_DISABLED   = 2'd0,
        ST_WAIT_CYCLE = 2'd1,
        ST_RUN        = 2'd2
    } state_e;

    // One aging step with the intermediate SOFT level; 2'b11 is treated as HARD.
    function automatic logic [1:0] age_soft(input logic [1:0] claim);
        logic [1:0] nxt;
        nxt = CLAIM_UNCLAIMED;
        if (claim[1]) begin
            nxt = CLAIM_SOFT;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dplca_age_counter.sv
// Counts beacons while aging is ON; emits a wrap pulse on the last beacon of an age period and
// holds new_age for the whole following PLCA cycle (cleared by the next beacon).
module dplca_age_counter
    import dplca_pkg::*;
#(
    parameter int AGING_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic step_i,
    input  logic aging_i,
    output logic wrap_o,
    output logic new_age_o
);

    localparam logic [7:0] LAST = 8'(AGING_CYCLES - 1);

    logic [7:0] age_cnt_q, age_cnt_d;
    logic       new_age_q, new_age_d;

    assign wrap_o    = step_i && (aging_i == ON) && (age_cnt_q == LAST);
    assign new_age_o = new_age_q;

    always_comb begin
        age_cnt_d = age_cnt_q;
        new_age_d = new_age_q;
        if (clr_i) begin
            age_cnt_d = '0;
            new_age_d = 1'b0;
        end else begin
            if (aging_i != ON) begin
                age_cnt_d = '0;
            end
            if (step_i) begin
                new_age_d = 1'b0;
                if (aging_i == ON) begin
                    if (age_cnt_q == LAST) begin
                        age_cnt_d = '0;
                        new_age_d = 1'b1;
                    end else begin
                        age_cnt_d = age_cnt_q + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_cnt_q <= '0;
            new_age_q <= 1'b0;
        end else begin
            age_cnt_q <= age_cnt_d;
            new_age_q <= new_age_d;
        end
    end

endmodule

// File: rtl/dplca_txop_table.sv
// DPLCA TXOP claim table: one 2-bit claim per TXOP ID, updated from txop_end/beacon activity.
// Define DPLCA_SOFT_CLAIM_EN to age HARD->SOFT->UNCLAIMED instead of HARD->UNCLAIMED.
module dplca_txop_table
    import dplca_pkg::*;
#(
    parameter int AGING_CYCLES = 32,
    parameter int NODE_ID_W    = NODE_ID_W_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            plca_en,
    input  logic                            dplca_en,
    input  logic                            dplca_aging,
    input  logic                            beacon_det,
    input  logic                            txop_end,
    input  logic                            txop_active,
    input  logic [NODE_ID_W-1:0]            cur_id,
    input  logic [NODE_ID_W-1:0]            plca_node_count,
    output logic [2*(1<<NODE_ID_W)-1:0]     txop_claim_table_unpacked,
    output logic                            dplca_txop_table_upd,
    output logic                            dplca_new_age,
    output logic [NODE_ID_W-1:0]            dplca_txop_id,
    output logic [NODE_ID_W-1:0]            dplca_txop_node_count
);

    localparam int DEPTH = 1 << NODE_ID_W;

    state_e               state_q, state_d;
    logic [1:0]           table_q [DEPTH];
    logic [1:0]           table_d [DEPTH];
    logic                 upd_q, upd_d;
    logic [NODE_ID_W-1:0] txop_id_q, txop_id_d;
    logic [NODE_ID_W-1:0] node_cnt_q, node_cnt_d;

    logic en, run, claim_hit, age_wrap;

    assign en        = plca_en && dplca_en;
    assign run       = en && (state_q == ST_RUN);
    assign claim_hit = run && txop_end && txop_active && (cur_id < plca_node_count);

    dplca_age_counter #(
        .AGING_CYCLES (AGING_CYCLES)
    ) u_age (
        .clk       (clk),
        .rst       (reset),
        .clr_i     (!en),
        .step_i    (run && beacon_det),
        .aging_i   (dplca_aging),
        .wrap_o    (age_wrap),
        .new_age_o (dplca_new_age)
    );

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED:   state_d = ST_WAIT_CYCLE;
                ST_WAIT_CYCLE: if (beacon_det) state_d = ST_RUN;
                ST_RUN:        state_d = ST_RUN;
                default:       state_d = ST_DISABLED;
            endcase
        end
    end

    // Aging is applied first so a coincident claim on cur_id overrides it.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            table_d[i] = table_q[i];
            if (!en) begin
                table_d[i] = CLAIM_UNCLAIMED;
            end else if (age_wrap) begin
`ifdef DPLCA_SOFT_CLAIM_EN
                table_d[i] = age_soft(table_q[i]);
`else
                table_d[i] = CLAIM_UNCLAIMED;
`endif
            end
        end
        if (claim_hit) begin
            table_d[cur_id] = CLAIM_HARD;
        end
    end

    always_comb begin
        upd_d      = run && beacon_det;
        txop_id_d  = txop_id_q;
        node_cnt_d = node_cnt_q;
        if (!en) begin
            txop_id_d  = '0;
            node_cnt_d = '0;
        end else begin
            if (run && txop_end)   txop_id_d  = cur_id;
            if (run && beacon_det) node_cnt_d = plca_node_count;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_DISABLED;
            upd_q      <= 1'b0;
            txop_id_q  <= '0;
            node_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= CLAIM_UNCLAIMED;
            end
        end else begin
            state_q    <= state_d;
            upd_q      <= upd_d;
            txop_id_q  <= txop_id_d;
            node_cnt_q <= node_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign txop_claim_table_unpacked[2*g +: 2] = table_q[g];
    end

    assign dplca_txop_table_upd  = upd_q;
    assign dplca_txop_id         = txop_id_q;
    assign dplca_txop_node_count = node_cnt_q;

endmodule
